serial_frame_tx: RTL and testbench

- Parametrised serial frame transmitter for the token-router link. Generalises the fixed 6-bit-sync / 55-bit-payload transmitter.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single registered line, preceded by a configurable sync pattern.
- Bit period is programmable in clocks. A synchronous abort is supported.
- Sits between the router core's TX path and the physical serial link, and pairs with the matching receiver.

---
 rtl/serial_link_pkg.sv | 24 ++
 rtl/serial_bit_timer.sv | 35 +++
 rtl/serial_frame_tx.sv | 157 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the token-router serial link (transmitter and receiver).
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        DONE
    } link_state_e;

    localparam logic [5:0] SYNC_PAT_DEFAULT = 6'b011111;
    localparam logic       LINK_IDLE_LEVEL  = 1'b0;

    // Width that holds any bit or clock count loaded by the link FSMs.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks per serial bit and strobes bit_tick
// on the last clock of each bit. restart reloads the count for a fresh frame.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_W        = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic bit_tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_q;
    logic [CNT_W-1:0] clk_cnt_d;

    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (restart) begin
            clk_cnt_d = RELOAD;
        end else if (en) begin
            clk_cnt_d = (clk_cnt_q == '0) ? RELOAD : clk_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) clk_cnt_q <= '0;
        else     clk_cnt_q <= clk_cnt_d;
    end

    assign bit_tick = en && (clk_cnt_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync pattern then payload MSB first on a registered line.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after the payload.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int                DATA_W       = 55,
    parameter int                SYNC_W       = 6,
    parameter logic [SYNC_W-1:0] SYNC_PAT     = SYNC_W'(SYNC_PAT_DEFAULT),
    parameter int                CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              abort,
    output logic              s_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(DATA_W, SYNC_W, CLKS_PER_BIT);

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              s_data_q, s_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              accept;
    logic              bit_tick;
    logic              timer_en;
    logic [SYNC_W-1:0] sync_sel;
    logic [DATA_W-1:0] data_sel;

    // abort wins over a simultaneous accept in IDLE.
    assign tx_ready = (state_q == IDLE);
    assign accept   = tx_valid && tx_ready && !abort;
    assign timer_en = (state_q == SYNC) || (state_q == DATA) || (state_q == PARITY);
    assign sync_sel = SYNC_PAT >> bit_cnt_q;
    assign data_sel = shift_q >> bit_cnt_q;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (timer_en),
        .restart  (accept),
        .bit_tick (bit_tick)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        s_data_d  = LINK_IDLE_LEVEL;
        busy_d    = (state_q != IDLE);
        done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SYNC;
                    bit_cnt_d = CNT_W'(SYNC_W - 1);
                    shift_d   = tx_data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            SYNC: begin
                s_data_d = sync_sel[0];
                if (bit_tick) begin
                    if (bit_cnt_q == '0) begin
                        state_d   = DATA;
                        bit_cnt_d = CNT_W'(DATA_W - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
            DATA: begin
                s_data_d = data_sel[0];
                if (bit_tick) begin
                    if (bit_cnt_q == '0) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                s_data_d = parity_q;
                if (bit_tick) state_d = DONE;
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            s_data_d = LINK_IDLE_LEVEL;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    // NOTE: the payload register is reset too; it is a plain word, not a memory array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            s_data_q  <= LINK_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            s_data_q  <= s_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

    assign s_data = s_data_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized self-checking bench for serial_frame_tx: a default-parameter instance and
// a small 4-bit-sync / 8-bit-payload / 3-clocks-per-bit instance, checked cycle by cycle.
module tb_serial_frame_tx;

    localparam int          A_DW  = 55;
    localparam int          A_SW  = 6;
    localparam int          A_CPB = 1;
    localparam logic [63:0] A_PAT = 64'b011111;
    localparam int          B_DW  = 8;
    localparam int          B_SW  = 4;
    localparam int          B_CPB = 3;
    localparam logic [63:0] B_PAT = 64'b1010;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        abort;
    logic        sel;

    logic a_ready, a_s, a_busy, a_done;
    logic b_ready, b_s, b_busy, b_done;
    logic [3:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_no = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    serial_frame_tx u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data[A_DW-1:0]),
        .tx_valid (tx_valid & ~sel),
        .tx_ready (a_ready),
        .abort    (abort & ~sel),
        .s_data   (a_s),
        .busy     (a_busy),
        .done     (a_done)
    );

    serial_frame_tx #(
        .DATA_W       (B_DW),
        .SYNC_W       (B_SW),
        .SYNC_PAT     (4'b1010),
        .CLKS_PER_BIT (B_CPB)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data[B_DW-1:0]),
        .tx_valid (tx_valid & sel),
        .tx_ready (b_ready),
        .abort    (abort & sel),
        .s_data   (b_s),
        .busy     (b_busy),
        .done     (b_done)
    );

    // Observed vector: {s_data, busy, done, tx_ready} of the instance under test.
    assign obs = sel ? {b_s, b_busy, b_done, b_ready} : {a_s, a_busy, a_done, a_ready};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line contents of one frame, one entry per clock.
    function automatic void build_frame(input logic [63:0] data);
        int          sw, dw, cpb;
        logic [63:0] pat;
        bit          par;
        sw  = sel ? B_SW : A_SW;
        dw  = sel ? B_DW : A_DW;
        cpb = sel ? B_CPB : A_CPB;
        pat = sel ? B_PAT : A_PAT;
        par = 1'b0;
        exp_bits.delete();
        for (int j = sw - 1; j >= 0; j--) repeat (cpb) exp_bits.push_back(pat[j]);
        for (int j = dw - 1; j >= 0; j--) begin
            repeat (cpb) exp_bits.push_back(data[j]);
            par ^= data[j];
        end
        if (PAR != 0) repeat (cpb) exp_bits.push_back(par);
    endfunction

    // Called at a negedge with the selected instance idle. cut_kind: 0 none, 1 abort, 2 reset.
    // With hold set, tx_valid stays high through the frame and into the next accept.
    task automatic run_frame(input logic [63:0] data, input bit hold, input int cut_at, input int cut_kind);
        int         len;
        logic [3:0] exp;
        string      tag;
        build_frame(data);
        len = exp_bits.size();
        frame_no++;
        tx_data  = data;
        tx_valid = 1'b1;
        for (int i = 0; i <= len + 1; i++) begin
            @(negedge clk);
            tag = $sformatf("%s_f%0d_c%0d", sel ? "B" : "A", frame_no, i);
            if (i == 0)        exp = 4'b0000;
            else if (i <= len) exp = {exp_bits[i-1], 3'b100};
            else               exp = 4'b0111;
            check(tag, obs, exp);
            if (i == 0) begin
                tx_data = {$urandom, $urandom};
                if (!hold) tx_valid = 1'b0;
            end
            if (i == cut_at && cut_kind == 1) begin
                abort = 1'b1;
                @(negedge clk);
                check({tag, "_abort"}, obs, 4'b0001);
                abort    = 1'b0;
                tx_valid = 1'b0;
                @(negedge clk);
                check({tag, "_abort_idle"}, obs, 4'b0001);
                return;
            end
            if (i == cut_at && cut_kind == 2) begin
                #2 rst = 1'b1;
                #1 check({tag, "_async_rst"}, obs, 4'b0001);
                tx_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check({tag, "_rst_idle"}, obs, 4'b0001);
                return;
            end
        end
        if (!hold) begin
            @(negedge clk);
            check($sformatf("%s_f%0d_idle", sel ? "B" : "A", frame_no), obs, 4'b0001);
        end
    endtask

    task automatic abort_in_idle();
        tx_data  = {$urandom, $urandom};
        tx_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        check("idle_abort_blocks_accept", obs, 4'b0001);
        tx_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        check("idle_abort_still_idle", obs, 4'b0001);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        abort    = 1'b0;
        sel      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_A", obs, 4'b0001);
        sel = 1'b1;
        #1 check("reset_B", obs, 4'b0001);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Default instance: known pattern, random back-to-back, abort, reset.
        run_frame(64'h1, 1'b0, -1, 0);
        run_frame({$urandom, $urandom}, 1'b1, -1, 0);
        run_frame({$urandom, $urandom}, 1'b1, -1, 0);
        run_frame({$urandom, $urandom}, 1'b0, -1, 0);
        run_frame({$urandom, $urandom}, 1'b0, 10, 1);
        run_frame({$urandom, $urandom}, 1'b0, -1, 0);
        abort_in_idle();
        run_frame({$urandom, $urandom}, 1'b0, 20, 2);
        run_frame({$urandom, $urandom}, 1'b0, -1, 0);

        sel = 1'b1;
        @(negedge clk);
        run_frame(64'hA5, 1'b0, -1, 0);
        run_frame(64'h07, 1'b0, -1, 0);
        run_frame(64'h03, 1'b0, -1, 0);
        for (int n = 0; n < 4; n++) run_frame({$urandom, $urandom}, (n < 3), -1, 0);
        run_frame({$urandom, $urandom}, 1'b0, 10, 1);
        run_frame({$urandom, $urandom}, 1'b0, -1, 0);
        abort_in_idle();
        run_frame({$urandom, $urandom}, 1'b0, 17, 2);
        run_frame(64'hFF, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
